aes256_key_schedule_ctrl: RTL

- Iterative AES-256 key-schedule sequencer.
- Accepts a 256-bit cipher key through a valid/ready handshake.
- Reuses a single combinational half-key expansion step, with the round number selected at run time, and streams the 15 round keys rk0..rk14 (128 bit each) in encryption order through a valid/ready output with backpressure.
- Sits between the key-load interface and the round datapath or round-key store.

---
 rtl/aes256_key_schedule_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/aes256_key_schedule_ctrl.sv
// AES-256 key-schedule sequencer: accepts a 256-bit key and streams round keys rk0..rk14 in encryption order.
// Latency: rk0 is valid the cycle after key accept; with PIPE_STAGE=1 there is a one-cycle bubble before each of rk2..rk14.
// Backpressure: rk_data/rk_idx/rk_last hold while rk_ready=0; key_ready stays low for the whole stream.

// Single combinational AES forward S-box, table based.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte of the table, so the bit offset is (255-a)*8 = {~a, 3'b000}.
    logic [7:0] a_inv;
    assign a_inv = ~a;
    assign s     = SBOX_TABLE[{a_inv, 3'b000} +: 8];
endmodule

module aes256_key_schedule_ctrl #(
    parameter int PIPE_STAGE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] key,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         rk_last,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OUT  = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;

    localparam logic [3:0] LAST_IDX = 4'd14;

    logic [1:0]   state_q,   state_d;
    logic [127:0] prev_q,    prev_d;
    logic [127:0] cur_q,     cur_d;
    logic [127:0] rk_data_q, rk_data_d;
    logic [3:0]   rk_idx_q,  rk_idx_d;

    // Expansion step: round n = rk_idx+1 derived from the two most recent half-keys.
    logic [3:0]   idx_n;
    logic [31:0]  t_word;
    logic [31:0]  sb_in;
    logic [31:0]  sb_out;
    logic [7:0]   rcon_byte;
    logic [31:0]  t_mix;
    logic [31:0]  o1, o2, o3, o4;
    logic [127:0] exp_key;

    assign idx_n  = rk_idx_q + 4'd1;
    assign t_word = cur_q[31:0];

    // Even rounds rotate before substitution; byte rotation commutes with SubWord so the order is free.
    assign sb_in = idx_n[0] ? t_word : {t_word[23:0], t_word[31:24]};

    aes_sbox u_sbox0 (.a(sb_in[31:24]), .s(sb_out[31:24]));
    aes_sbox u_sbox1 (.a(sb_in[23:16]), .s(sb_out[23:16]));
    aes_sbox u_sbox2 (.a(sb_in[15:8]),  .s(sb_out[15:8]));
    aes_sbox u_sbox3 (.a(sb_in[7:0]),   .s(sb_out[7:0]));

    // Rcon[n/2] for n = 2..14 is 0x01 << (n/2 - 1); odd rounds add no round constant.
    assign rcon_byte = idx_n[0] ? 8'h00 : (8'h01 << (idx_n[3:1] - 3'd1));
    assign t_mix     = sb_out ^ {rcon_byte, 24'h000000};

    assign o1      = prev_q[127:96] ^ t_mix;
    assign o2      = prev_q[95:64]  ^ o1;
    assign o3      = prev_q[63:32]  ^ o2;
    assign o4      = prev_q[31:0]   ^ o3;
    assign exp_key = {o1, o2, o3, o4};

    // Next-state logic: key load, per-handshake advance and optional result-register bubble.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        cur_d     = cur_q;
        rk_data_d = rk_data_q;
        rk_idx_d  = rk_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    prev_d    = key[255:128];
                    cur_d     = key[127:0];
                    rk_data_d = key[255:128];
                    rk_idx_d  = 4'd0;
                    state_d   = ST_OUT;
                end
            end
            ST_OUT: begin
                if (rk_ready) begin
                    if (rk_idx_q == LAST_IDX) begin
                        // Stream complete; key_ready rises next cycle, never same-cycle.
                        rk_idx_d = 4'd0;
                        state_d  = ST_IDLE;
                    end else if (rk_idx_q == 4'd0) begin
                        // rk1 is the second key half and needs no expansion.
                        rk_data_d = cur_q;
                        rk_idx_d  = 4'd1;
                    end else begin
                        prev_d   = cur_q;
                        cur_d    = exp_key;
                        rk_idx_d = idx_n;
                        if (PIPE_STAGE == 0) begin
                            rk_data_d = exp_key;
                        end else begin
                            state_d = ST_CALC;
                        end
                    end
                end
            end
            ST_CALC: begin
                // cur_q already holds the registered expansion result.
                rk_data_d = cur_q;
                state_d   = ST_OUT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prev_q    <= '0;
            cur_q     <= '0;
            rk_data_q <= '0;
            rk_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            cur_q     <= cur_d;
            rk_data_q <= rk_data_d;
            rk_idx_q  <= rk_idx_d;
        end
    end

    assign key_ready = (state_q == ST_IDLE);
    assign rk_valid  = (state_q == ST_OUT);
    assign rk_last   = (state_q == ST_OUT) && (rk_idx_q == LAST_IDX);
    assign busy      = (state_q != ST_IDLE);
    assign rk_data   = rk_data_q;
    assign rk_idx    = rk_idx_q;
endmodule
